dual_branch_predictor: RTL and testbench

- Dual-ported branch history table of 2-bit saturating counters for the dual-issue pipeline.
- Fetch stage: two lookups per cycle supply `prediction_1` and `prediction_2` for the two fetched instructions.
- Execute stage: up to two resolved branch outcomes per cycle are written back. Inst1 is always the older instruction.
- Simultaneous updates to the same entry are merged in program order.
- A sequenced clear FSM reinitialises the table without a global reset.

---
 rtl/dual_branch_predictor.sv | 105 ++++++++++
 tb/tb_dual_branch_predictor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_branch_predictor.sv
// Dual-ported 2-bit saturating-counter branch history table with a sequenced clear sweep.
// Optional macro BP_BYPASS_EN forwards same-cycle update results to the fetch lookups.
module dual_branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc_fetch_1,
    input  logic [PC_WIDTH-1:0] pc_fetch_2,
    output logic                prediction_1,
    output logic                prediction_2,
    input  logic                BranchExecute_1,
    input  logic                BranchExecute_2,
    input  logic [PC_WIDTH-1:0] branch_pc_1,
    input  logic [PC_WIDTH-1:0] branch_pc_2,
    input  logic                actual_prediction_1,
    input  logic                actual_prediction_2,
    input  logic                clear_table,
    output logic                bp_busy
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS:0] LAST_PTR = (INDEX_BITS + 1)'(ENTRIES - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    logic [INDEX_BITS:0] ptr;
    logic [1:0]          bht [ENTRIES];

    logic [INDEX_BITS-1:0] fidx1, fidx2, uidx1, uidx2;
    logic                  upd1, upd2;
    logic [1:0]            new1, base2, new2, look1, look2;
    logic                  unused_pc_bits;

    function automatic logic [1:0] step(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'b01;
        else       return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign fidx1 = pc_fetch_1[INDEX_BITS+1:2];
    assign fidx2 = pc_fetch_2[INDEX_BITS+1:2];
    assign uidx1 = branch_pc_1[INDEX_BITS+1:2];
    assign uidx2 = branch_pc_2[INDEX_BITS+1:2];

    assign unused_pc_bits = ^{pc_fetch_1[PC_WIDTH-1:INDEX_BITS+2], pc_fetch_1[1:0],
                              pc_fetch_2[PC_WIDTH-1:INDEX_BITS+2], pc_fetch_2[1:0],
                              branch_pc_1[PC_WIDTH-1:INDEX_BITS+2], branch_pc_1[1:0],
                              branch_pc_2[PC_WIDTH-1:INDEX_BITS+2], branch_pc_2[1:0]};

    assign upd1 = BranchExecute_1 && (state == IDLE);
    assign upd2 = BranchExecute_2 && (state == IDLE);

    // inst2 steps from inst1's result when both hit the same entry (program order)
    assign new1  = step(bht[uidx1], actual_prediction_1);
    assign base2 = (upd1 && (uidx1 == uidx2)) ? new1 : bht[uidx2];
    assign new2  = step(base2, actual_prediction_2);

    always_comb begin
        look1 = bht[fidx1];
        look2 = bht[fidx2];
`ifdef BP_BYPASS_EN
        // new2 already carries the merged value for a same-index pair, so it overrides new1
        if (upd1 && (uidx1 == fidx1)) look1 = new1;
        if (upd2 && (uidx2 == fidx1)) look1 = new2;
        if (upd1 && (uidx1 == fidx2)) look2 = new1;
        if (upd2 && (uidx2 == fidx2)) look2 = new2;
`endif
        prediction_1 = (state == IDLE) && look1[1];
        prediction_2 = (state == IDLE) && look2[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
            state   <= IDLE;
            ptr     <= '0;
            bp_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (upd1) bht[uidx1] <= new1;
                    if (upd2) bht[uidx2] <= new2;
                    if (clear_table) begin
                        state   <= CLEAR;
                        ptr     <= '0;
                        bp_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    bht[ptr[INDEX_BITS-1:0]] <= 2'b01;
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_PTR) begin
                        state   <= IDLE;
                        bp_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bp_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dual_branch_predictor.sv
// Directed bench for dual_branch_predictor: table model checked every negedge plus literal pins.
module tb_dual_branch_predictor;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_fetch_1 = '0, pc_fetch_2 = '0;
    logic        prediction_1, prediction_2;
    logic        BranchExecute_1 = 1'b0, BranchExecute_2 = 1'b0;
    logic [31:0] branch_pc_1 = '0, branch_pc_2 = '0;
    logic        actual_prediction_1 = 1'b0, actual_prediction_2 = 1'b0;
    logic        clear_table = 1'b0;
    logic        bp_busy;

    always #5 clk = ~clk;

    dual_branch_predictor #(.INDEX_BITS(6), .PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .pc_fetch_1(pc_fetch_1), .pc_fetch_2(pc_fetch_2),
        .prediction_1(prediction_1), .prediction_2(prediction_2),
        .BranchExecute_1(BranchExecute_1), .BranchExecute_2(BranchExecute_2),
        .branch_pc_1(branch_pc_1), .branch_pc_2(branch_pc_2),
        .actual_prediction_1(actual_prediction_1), .actual_prediction_2(actual_prediction_2),
        .clear_table(clear_table), .bp_busy(bp_busy)
    );

    int ncmp = 0;
    int nerr = 0;
    int m [N];
    int busy_left = 0;

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ix(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int stepv(input int v, input logic taken);
        if (taken) return (v == 3) ? 3 : v + 1;
        return (v == 0) ? 0 : v - 1;
    endfunction

    // Model: counters as plain ints; dual updates simply applied in program order.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            foreach (m[i]) m[i] = 1;
            busy_left = 0;
        end else if (busy_left > 0) begin
            m[N - busy_left] = 1;
            busy_left--;
        end else begin
            if (BranchExecute_1) m[ix(branch_pc_1)] = stepv(m[ix(branch_pc_1)], actual_prediction_1);
            if (BranchExecute_2) m[ix(branch_pc_2)] = stepv(m[ix(branch_pc_2)], actual_prediction_2);
            if (clear_table) busy_left = N;
        end
    end

    function automatic int exp_pred(input logic [31:0] pc);
        int v;
        if (busy_left > 0) return 0;
        v = m[ix(pc)];
`ifdef BP_BYPASS_EN
        if (BranchExecute_1 && ix(branch_pc_1) == ix(pc)) v = stepv(v, actual_prediction_1);
        if (BranchExecute_2 && ix(branch_pc_2) == ix(pc)) v = stepv(v, actual_prediction_2);
`endif
        return (v >= 2) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        chk("pred1", int'(prediction_1), exp_pred(pc_fetch_1));
        chk("pred2", int'(prediction_2), exp_pred(pc_fetch_2));
        chk("busy", int'(bp_busy), (busy_left > 0) ? 1 : 0);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        BranchExecute_1 = 1'b0;
        BranchExecute_2 = 1'b0;
        clear_table     = 1'b0;
    endtask

    task automatic upd1(input logic [31:0] pc, input logic t);
        BranchExecute_1 = 1'b1; branch_pc_1 = pc; actual_prediction_1 = t;
        cyc();
    endtask

    task automatic dual(input logic [31:0] p1, input logic t1, input logic [31:0] p2, input logic t2);
        BranchExecute_1 = 1'b1; branch_pc_1 = p1; actual_prediction_1 = t1;
        BranchExecute_2 = 1'b1; branch_pc_2 = p2; actual_prediction_2 = t2;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] PA = 32'h0040_0000;
    localparam logic [31:0] PB = 32'h0040_0010;
    localparam logic [31:0] PC = 32'h0040_0020;
    localparam logic [31:0] PD = 32'h0040_0030;

    initial begin
        int n;
        int bad;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        pc_fetch_1 = PA;
        #1;
        chk("reset_pred", int'(prediction_1), 0);
        chk("reset_busy", int'(bp_busy), 0);
        chk("reset_entry", m[0], 1);

        // three taken -> strong taken
        repeat (3) upd1(PA, 1'b1);
        chk("three_taken_entry", m[0], 3);
        chk("three_taken_pred", int'(prediction_1), 1);

        // same-index merge from 10 and from 11
        pc_fetch_2 = PB;
        upd1(PB, 1'b1);
        dual(PB, 1'b1, PB, 1'b0);
        chk("merge_from10_entry", m[4], 2);
        chk("merge_from10_pred", int'(prediction_2), 1);
        upd1(PB, 1'b1);
        dual(PB, 1'b1, PB, 1'b0);
        chk("merge_from11_entry", m[4], 2);
        upd1(PB, 1'b0);
        chk("merge_followup_pred", int'(prediction_2), 0);

        // saturation both ways
        pc_fetch_1 = PC;
        repeat (5) upd1(PC, 1'b0);
        chk("sat_low_entry", m[8], 0);
        chk("sat_low_pred", int'(prediction_1), 0);
        repeat (5) upd1(PC, 1'b1);
        chk("sat_high_entry", m[8], 3);
        chk("sat_high_pred", int'(prediction_1), 1);
        upd1(PC, 1'b0);
        chk("sat_high_step_down", int'(prediction_1), 1);

        // different indices
        pc_fetch_1 = 32'h4;
        pc_fetch_2 = 32'h8;
        dual(32'h4, 1'b1, 32'h8, 1'b1);
        chk("diff_entry1", m[1], 2);
        chk("diff_entry2", m[2], 2);
        chk("diff_neighbour", m[3], 1);
        chk("diff_pred1", int'(prediction_1), 1);
        chk("diff_pred2", int'(prediction_2), 1);
        dual(32'h4, 1'b0, 32'h8, 1'b1);

        // same-cycle update vs lookup
        pc_fetch_1 = PD;
        BranchExecute_1 = 1'b1; branch_pc_1 = PD; actual_prediction_1 = 1'b1;
        #2;
`ifdef BP_BYPASS_EN
        chk("bypass_same_cycle", int'(prediction_1), 1);
`else
        chk("bypass_same_cycle", int'(prediction_1), 0);
`endif
        cyc();
        chk("bypass_next_cycle", int'(prediction_1), 1);
        pc_fetch_2 = 32'h0040_0040;
        dual(32'h0040_0040, 1'b1, 32'h0040_0040, 1'b1);

        // clear sweep with a concurrent update, then a dropped mid-sweep update
        BranchExecute_1 = 1'b1; branch_pc_1 = PB; actual_prediction_1 = 1'b1;
        clear_table = 1'b1;
        cyc();
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (!bp_busy) break;
            n++;
            if (n == 10) begin
                BranchExecute_1 = 1'b1; branch_pc_1 = 32'h14; actual_prediction_1 = 1'b1;
                clear_table = 1'b1;
            end
            cyc();
        end
        chk("clear_length", n, 64);
        bad = 0;
        foreach (m[i]) if (m[i] != 1) bad++;
        chk("clear_model_all01", bad, 0);
        pc_fetch_1 = 32'h14;
        #1;
        chk("dropped_update", int'(prediction_1), 0);
        for (int i = 0; i < N; i++) begin
            pc_fetch_2 = 32'(i * 4);
            #1;
            chk("post_clear_pred", int'(prediction_2), 0);
        end
        pc_fetch_1 = PA;
        upd1(PA, 1'b1);
        chk("post_clear_weak_nt", int'(prediction_1), 1);

        // reset in the middle of a sweep
        upd1(32'hA0, 1'b1);
        upd1(32'hA0, 1'b1);
        clear_table = 1'b1;
        cyc();
        repeat (20) cyc();
        chk("midclear_busy_before", int'(bp_busy), 1);
        reset = 1'b1;
        #1;
        chk("midclear_reset_busy", int'(bp_busy), 0);
        #1 reset = 1'b0;
        pc_fetch_1 = 32'hA0;
        #1;
        chk("midclear_reset_entry", int'(prediction_1), 0);
        cyc();
        upd1(32'hA0, 1'b1);
        chk("midclear_after_taken", int'(prediction_1), 1);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
